dpc_frame_ctrl: RTL and testbench
=================================

Name: dpc_frame_ctrl

Overview:
Frame-level sequencer for the DPC corrector. It snoops the corrector's input and output AXI4-Stream handshakes and drives the corrector's `enable` only at frame boundaries, so correction is never switched mid-frame. It runs a start/stop/frame-count run sequence, checks frame geometry, and reports per-frame corrected-pixel counts and sticky error flags to the register bank.

Parameters:
FRAME_WIDTH, 640, pixels per line
FRAME_HEIGHT, 512, lines per frame
CNT_WIDTH, 10, column/row counter width
BP_CNT_WIDTH, 20, corrected-pixel counter width (saturating)
NFRM_WIDTH, 16, frame-count config/status width
TIMEOUT_CYCLES, 65536, stall limit (optional feature only)

Ports:
aclk  in  1  clock; single clock domain
areset  in  1  asynchronous, active-high reset
cfg_start  in  1  one-cycle pulse: arm a run
cfg_stop  in  1  one-cycle pulse: end run after the current input frame
cfg_enable  in  1  requested correction enable, shadowed at SOF
cfg_num_frames  in  NFRM_WIDTH  frames per run; 0 = continuous
s_tvalid, s_tready, s_tuser, s_tlast  in  1 each  corrector input handshake (snoop)
m_tvalid, m_tready, m_tuser, m_tlast  in  1 each  corrector output handshake (snoop)
bp_corrected  in  1  corrector debug_bp_corrected, aligned with m_tvalid
dpc_enable  out  1  drives corrector enable
busy  out  1  run active or output frame outstanding
frame_done  out  1  one-cycle pulse on the final output beat of a frame
frames_done  out  NFRM_WIDTH  frames completed in the current run
bp_count_last  out  BP_CNT_WIDTH  corrected pixels in the last completed frame
err_sof  out  1  sticky: unexpected SOF
err_line  out  1  sticky: tlast at the wrong column, or missing at the last column
err_timeout  out  1  sticky: stall watchdog fired (0 without the optional feature)

Behaviour:
- Reset (async, areset=1): state IDLE; all counters 0; every output 0.
- Beats: in_beat = s_tvalid&s_tready; out_beat = m_tvalid&m_tready.
- FSM states IDLE, ARMED, ACTIVE:
  - IDLE: cfg_start -> ARMED; frames_done cleared; errors cleared.
  - ARMED: in_beat with s_tuser -> ACTIVE. In-beats without s_tuser are ignored; no error.
  - ACTIVE: after the final input beat (row=FRAME_HEIGHT-1, col=FRAME_WIDTH-1), the next state is:
    - IDLE if stop is pending, or if cfg_num_frames≠0 and started frames = cfg_num_frames;
    - otherwise ARMED.
- cfg_stop in ARMED -> IDLE immediately. cfg_stop in ACTIVE sets stop pending. cfg_start outside IDLE is ignored. If start and stop coincide in IDLE, start wins.
- dpc_enable: on the edge accepting an SOF in ARMED, it loads cfg_enable. It holds for the whole frame and clears on entering IDLE. This matches the corrector's 1-cycle stage offset, so the SOF pixel sees the new value.
- Input geometry (ACTIVE):
  - col increments per in_beat and wraps at FRAME_WIDTH-1; row increments on wrap.
  - s_tlast at col≠FRAME_WIDTH-1, or absent at col=FRAME_WIDTH-1 -> err_line set. Counters follow position, not tlast.
  - s_tuser at any position other than (0,0) -> err_sof set, counters restart at (0,1), frame treated as new. Stop/frame-limit checks apply to the new frame.
- Output side, independent of the FSM so frames can overlap the 2-cycle pipeline:
  - out_col/out_row counters advance per out_beat.
  - Per-frame bp counter increments on out_beat&bp_corrected and saturates at all-ones.
  - On out_beat at the final output position: frame_done=1 for one cycle; bp_count_last <= counter including the current beat; counter cleared; frames_done increments (wraps).
  - m_tuser resyncs out counters to (0,1) with no error.
- busy = (state≠IDLE) | (output frames started minus completed ≠ 0).
- Sticky errors hold until cfg_start is accepted from IDLE.

Optional Feature:
DPC_CTRL_TIMEOUT_EN:
- Defined: in ACTIVE, a cycle counter resets on each in_beat. On reaching TIMEOUT_CYCLES-1 without a beat, it sets err_timeout, resets input counters, and returns to ARMED. dpc_enable is held until the next SOF.
- Undefined: no counter is built; err_timeout is tied to 0.

Test Plan:
- Reset, cfg_start, cfg_enable=1, cfg_num_frames=2, two clean 640x512 frames with 10 flagged pixels each -> dpc_enable goes 1 on the first SOF edge; two frame_done pulses; bp_count_last=10; frames_done=2; FSM returns to IDLE; dpc_enable=0.
- cfg_enable toggled mid-frame -> dpc_enable unchanged until the next SOF beat, then takes the new value.
- Line 3 gives tlast at col 638 -> err_line=1; row count still follows position; the flag persists until the next cfg_start.
- SOF injected at row 100 col 5 -> err_sof=1; counters restart; the following full frame completes with exactly one frame_done.
- cfg_stop during row 200 of continuous mode -> current frame completes and outputs drain; then IDLE, busy=0, no further dpc_enable.
- With DPC_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=16: stall input 16 cycles in ACTIVE -> err_timeout=1, state ARMED. Without the macro: err_timeout stays 0.

Source files
------------

// File: rtl/dpc_frame_ctrl_if.sv
// Snoop bundle for the corrector's input and output AXI4-Stream handshakes.
interface dpc_frame_ctrl_if;
  logic s_tvalid;
  logic s_tready;
  logic s_tuser;
  logic s_tlast;
  logic m_tvalid;
  logic m_tready;
  logic m_tuser;
  logic m_tlast;
  logic bp_corrected;

  modport master (
    output s_tvalid, s_tready, s_tuser, s_tlast,
    output m_tvalid, m_tready, m_tuser, m_tlast, bp_corrected
  );

  modport slave (
    input s_tvalid, s_tready, s_tuser, s_tlast,
    input m_tvalid, m_tready, m_tuser, m_tlast, bp_corrected
  );
endinterface

// File: rtl/dpc_frame_ctrl.sv
// Frame sequencer for the DPC corrector: switches enable only at SOF, checks geometry, counts corrected pixels.
// Define DPC_CTRL_TIMEOUT_EN to build the input stall watchdog (err_timeout is tied low otherwise).
module dpc_frame_ctrl #(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 512,
  parameter int CNT_WIDTH    = 10,
  parameter int BP_CNT_WIDTH = 20,
  parameter int NFRM_WIDTH   = 16
`ifdef DPC_CTRL_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 65536
`endif
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    cfg_start,
  input  logic                    cfg_stop,
  input  logic                    cfg_enable,
  input  logic [NFRM_WIDTH-1:0]   cfg_num_frames,
  dpc_frame_ctrl_if.slave         snoop,
  output logic                    dpc_enable,
  output logic                    busy,
  output logic                    frame_done,
  output logic [NFRM_WIDTH-1:0]   frames_done,
  output logic [BP_CNT_WIDTH-1:0] bp_count_last,
  output logic                    err_sof,
  output logic                    err_line,
  output logic                    err_timeout
);
  typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} state_t;

  localparam logic [CNT_WIDTH-1:0] COL_LAST = CNT_WIDTH'(FRAME_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] ROW_LAST = CNT_WIDTH'(FRAME_HEIGHT - 1);

  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    col_q, col_d, row_q, row_d, pos_col, pos_row;
  logic [NFRM_WIDTH-1:0]   started_q, started_d;
  logic                    stop_pend_q, stop_pend_d, en_q, en_d;
  logic                    err_sof_q, err_sof_d, err_line_q, err_line_d;
  logic                    in_beat, out_beat, start_acc, limit_hit, take_pos, restart;

  logic [CNT_WIDTH-1:0]    ocol_q, orow_q, ocol_pos, orow_pos;
  logic [BP_CNT_WIDTH-1:0] bp_q, bp_last_q, bp_base, bp_next;
  logic [NFRM_WIDTH-1:0]   frames_q;
  logic                    open_q, done_q, out_last;

`ifdef DPC_CTRL_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_tmo_q, err_tmo_d;
`endif

  assign in_beat   = snoop.s_tvalid & snoop.s_tready;
  assign out_beat  = snoop.m_tvalid & snoop.m_tready;
  assign start_acc = (state_q == IDLE) & cfg_start;
  assign limit_hit = (cfg_num_frames != '0) && (started_q >= cfg_num_frames);

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    started_d   = started_q;
    stop_pend_d = stop_pend_q;
    en_d        = en_q;
    err_sof_d   = err_sof_q;
    err_line_d  = err_line_q;
    take_pos    = 1'b0;
    restart     = 1'b0;
`ifdef DPC_CTRL_TIMEOUT_EN
    err_tmo_d   = err_tmo_q;
    tmo_d       = '0;
`endif
    unique case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d     = ARMED;
          started_d   = '0;
          stop_pend_d = 1'b0;
          err_sof_d   = 1'b0;
          err_line_d  = 1'b0;
`ifdef DPC_CTRL_TIMEOUT_EN
          err_tmo_d   = 1'b0;
`endif
        end
      end
      ARMED: begin
        if (cfg_stop || stop_pend_q) begin
          state_d     = IDLE;
          stop_pend_d = 1'b0;
          en_d        = 1'b0;
        end else if (in_beat && snoop.s_tuser) begin
          state_d   = ACTIVE;
          en_d      = cfg_enable;
          started_d = started_q + 1'b1;
          take_pos  = 1'b1;
          restart   = 1'b1;
        end
      end
      ACTIVE: begin
        if (cfg_stop) stop_pend_d = 1'b1;
        if (in_beat) begin
          take_pos = 1'b1;
          if (snoop.s_tuser && ((col_q != '0) || (row_q != '0))) begin
            // Early SOF starts a fresh frame; it counts toward the run limit.
            err_sof_d = 1'b1;
            started_d = started_q + 1'b1;
            restart   = 1'b1;
          end else if ((col_q == COL_LAST) && (row_q == ROW_LAST)) begin
            if (stop_pend_q || cfg_stop || limit_hit) begin
              state_d     = IDLE;
              stop_pend_d = 1'b0;
              en_d        = 1'b0;
            end else begin
              state_d = ARMED;
            end
          end
        end
`ifdef DPC_CTRL_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          err_tmo_d = 1'b1;
          state_d   = ARMED;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    pos_col = restart ? '0 : col_q;
    pos_row = restart ? '0 : row_q;
    if (take_pos && (snoop.s_tlast != (pos_col == COL_LAST))) err_line_d = 1'b1;

    // Position tracks beats, never tlast, so a bad tlast cannot skew the row count.
    if (state_d != ACTIVE) begin
      col_d = '0;
      row_d = '0;
    end else if (take_pos) begin
      if (pos_col == COL_LAST) begin
        col_d = '0;
        row_d = (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
      end else begin
        col_d = pos_col + 1'b1;
        row_d = pos_row;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      started_q   <= '0;
      stop_pend_q <= 1'b0;
      en_q        <= 1'b0;
      err_sof_q   <= 1'b0;
      err_line_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      started_q   <= started_d;
      stop_pend_q <= stop_pend_d;
      en_q        <= en_d;
      err_sof_q   <= err_sof_d;
      err_line_q  <= err_line_d;
    end
  end

`ifdef DPC_CTRL_TIMEOUT_EN
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      tmo_q     <= '0;
      err_tmo_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      err_tmo_q <= err_tmo_d;
    end
  end
  assign err_timeout = err_tmo_q;
`else
  assign err_timeout = 1'b0;
`endif

  // Output side runs free of the FSM so it can trail the input by the pipeline depth.
  always_comb begin
    ocol_pos = snoop.m_tuser ? '0 : ocol_q;
    orow_pos = snoop.m_tuser ? '0 : orow_q;
    bp_base  = snoop.m_tuser ? '0 : bp_q;
    bp_next  = (snoop.bp_corrected && (bp_base != '1)) ? bp_base + 1'b1 : bp_base;
    out_last = (ocol_pos == COL_LAST) && (orow_pos == ROW_LAST);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ocol_q    <= '0;
      orow_q    <= '0;
      bp_q      <= '0;
      bp_last_q <= '0;
      frames_q  <= '0;
      open_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_acc) frames_q <= '0;
      if (out_beat) begin
        if (out_last) begin
          done_q    <= 1'b1;
          bp_last_q <= bp_next;
          bp_q      <= '0;
          open_q    <= 1'b0;
          ocol_q    <= '0;
          orow_q    <= '0;
          if (!start_acc) frames_q <= frames_q + 1'b1;
        end else begin
          bp_q <= bp_next;
          if (snoop.m_tuser) open_q <= 1'b1;
          if (ocol_pos == COL_LAST) begin
            ocol_q <= '0;
            orow_q <= orow_pos + 1'b1;
          end else begin
            ocol_q <= ocol_pos + 1'b1;
            orow_q <= orow_pos;
          end
        end
      end
    end
  end

  assign dpc_enable    = en_q;
  assign busy          = (state_q != IDLE) | open_q;
  assign frame_done    = done_q;
  assign frames_done   = frames_q;
  assign bp_count_last = bp_last_q;
  assign err_sof       = err_sof_q;
  assign err_line      = err_line_q;
endmodule

// File: tb/tb_dpc_frame_ctrl.sv
// Bench for dpc_frame_ctrl on a small 8x4 frame; corrector modelled as a 2-cycle delay line.
`timescale 1ns/1ps
module tb_dpc_frame_ctrl;
  localparam int W   = 8;
  localparam int H   = 4;
  localparam int PIX = W * H;
  localparam int NFW = 16;
  localparam int BPW = 20;

  typedef struct {int bp; int frames;} exp_t;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  logic cfg_start = 1'b0, cfg_stop = 1'b0, cfg_enable = 1'b0;
  logic [NFW-1:0] cfg_num_frames = '0;
  logic dpc_enable, busy, frame_done, err_sof, err_line, err_timeout;
  logic [NFW-1:0] frames_done;
  logic [BPW-1:0] bp_count_last;
  logic s_bp = 1'b0;
  logic [3:0] pipe1 = '0, pipe2 = '0;
  int n_checks = 0, n_pass = 0, exp_frames = 0, bad_idx = -1;
  exp_t exp_q[$];
  exp_t mon_e;

  dpc_frame_ctrl_if bus();

  dpc_frame_ctrl #(
    .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .CNT_WIDTH(10), .BP_CNT_WIDTH(BPW), .NFRM_WIDTH(NFW)
`ifdef DPC_CTRL_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .aclk(aclk), .areset(areset),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_enable(cfg_enable),
    .cfg_num_frames(cfg_num_frames),
    .snoop(bus),
    .dpc_enable(dpc_enable), .busy(busy), .frame_done(frame_done),
    .frames_done(frames_done), .bp_count_last(bp_count_last),
    .err_sof(err_sof), .err_line(err_line), .err_timeout(err_timeout)
  );

  always #5 aclk = ~aclk;

  // Corrector stand-in: output handshake is the input beat delayed two cycles.
  always @(posedge aclk) begin
    pipe1 <= {bus.s_tvalid & bus.s_tready, bus.s_tuser, bus.s_tlast, s_bp};
    pipe2 <= pipe1;
  end
  assign bus.m_tvalid     = pipe2[3];
  assign bus.m_tuser      = pipe2[2];
  assign bus.m_tlast      = pipe2[1];
  assign bus.bp_corrected = pipe2[0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  always @(negedge aclk) begin
    if (!areset && frame_done) begin
      chk("frame_done_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("bp_count_last", bp_count_last, mon_e.bp);
        chk("frames_done", frames_done, mon_e.frames);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic send_range(input int from, input int to, input int nbp);
    for (int p = from; p <= to; p++) begin
      bus.s_tvalid = 1'b1;
      bus.s_tuser  = (p == 0);
      bus.s_tlast  = (((p % W) == W - 1) != (p == bad_idx));
      s_bp         = (p < nbp);
      if (p == PIX - 1) begin
        exp_frames++;
        exp_q.push_back('{bp: nbp, frames: exp_frames});
      end
      @(posedge aclk);
      #1;
    end
    bus.s_tvalid = 1'b0;
    bus.s_tuser  = 1'b0;
    bus.s_tlast  = 1'b0;
    s_bp         = 1'b0;
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    @(posedge aclk);
    #1;
    cfg_start  = 1'b0;
    exp_frames = 0;
  endtask

  task automatic pulse_stop();
    cfg_stop = 1'b1;
    @(posedge aclk);
    #1;
    cfg_stop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached after %0d of %0d checks passed", n_pass, n_checks);
    $fatal(1, "bench time limit");
  end

  initial begin
    bus.s_tvalid = 1'b0;
    bus.s_tready = 1'b1;
    bus.s_tuser  = 1'b0;
    bus.s_tlast  = 1'b0;
    bus.m_tready = 1'b1;
    idle(3);
    chk("rst_dpc_enable", dpc_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frames_done", frames_done, 0);
    chk("rst_bp_count_last", bp_count_last, 0);
    chk("rst_err_sof", err_sof, 0);
    chk("rst_err_line", err_line, 0);
    chk("rst_err_timeout", err_timeout, 0);
    areset = 1'b0;
    idle(2);

    // Two-frame run with correction enabled.
    cfg_enable = 1'b1;
    cfg_num_frames = 16'd2;
    pulse_start();
    chk("armed_busy", busy, 1);
    send_range(5, 7, 0);
    chk("armed_ignores_non_sof", dpc_enable, 0);
    chk("armed_no_err_sof", err_sof, 0);
    chk("armed_no_err_line", err_line, 0);
    send_range(0, 0, 10);
    chk("enable_on_first_sof", dpc_enable, 1);
    send_range(1, PIX - 1, 10);
    send_range(0, PIX - 1, 10);
    idle(6);
    chk("run_end_busy", busy, 0);
    chk("run_end_enable", dpc_enable, 0);

    // Continuous run: enable changes only at SOF.
    cfg_num_frames = '0;
    cfg_enable = 1'b0;
    pulse_start();
    send_range(0, 15, 3);
    cfg_enable = 1'b1;
    send_range(16, PIX - 1, 3);
    chk("enable_held_until_sof", dpc_enable, 0);
    send_range(0, 0, 3);
    chk("enable_takes_new_value", dpc_enable, 1);
    cfg_enable = 1'b0;
    send_range(1, PIX - 1, 3);
    chk("enable_held_after_frame", dpc_enable, 1);

    // Early tlast on row 2.
    chk("err_line_before", err_line, 0);
    bad_idx = 2 * W + W - 2;
    send_range(0, PIX - 1, 5);
    bad_idx = -1;
    chk("err_line_set", err_line, 1);
    chk("err_sof_clean_after_line", err_sof, 0);
    send_range(0, PIX - 1, 0);
    chk("err_line_sticky", err_line, 1);

    // SOF injected at row 2 col 5.
    chk("err_sof_before", err_sof, 0);
    send_range(0, 2 * W + 4, 0);
    send_range(0, PIX - 1, 4);
    chk("err_sof_set", err_sof, 1);

    // Stop mid-frame: frame completes, then nothing more.
    send_range(0, 15, 2);
    pulse_stop();
    send_range(16, PIX - 1, 2);
    idle(6);
    chk("stop_busy", busy, 0);
    chk("stop_enable", dpc_enable, 0);
    cfg_enable = 1'b1;
    send_range(0, 3, 0);
    chk("idle_sof_no_enable", dpc_enable, 0);
    chk("err_sof_sticky_in_idle", err_sof, 1);
    idle(6);

    // Input stall in ACTIVE.
    pulse_start();
    chk("start_clears_err_sof", err_sof, 0);
    chk("start_clears_err_line", err_line, 0);
    send_range(0, 5, 0);
    idle(15);
    chk("timeout_below_limit", err_timeout, 0);
    idle(1);
`ifdef DPC_CTRL_TIMEOUT_EN
    chk("timeout_fired", err_timeout, 1);
    chk("timeout_enable_held", dpc_enable, 1);
    send_range(3, 5, 0);
    send_range(0, PIX - 1, 0);
`else
    idle(5);
    chk("timeout_absent", err_timeout, 0);
    send_range(6, PIX - 1, 0);
`endif
    pulse_stop();
    idle(6);
    chk("final_busy", busy, 0);
    chk("final_enable", dpc_enable, 0);
    idle(4);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
